io_port_responder: RTL and testbench

- Peripheral-side responder for the processor_top IO bus (IO_port_ID, IO_write_data, IO_write_strobe, IO_read_strobe, IO_read_data).
- Decodes port IDs and provides:
  - 4 GPIO output bytes
  - 1 synchronized GPIO input byte
  - a TX byte stream FIFO fed by processor writes
  - an RX byte stream FIFO drained by processor reads
  - a status register
- Sits beside processor_top at top level; replaces the fixed IO_read_data stimulus used in simulation.

---
 rtl/io_port_pkg.sv | 27 ++
 rtl/io_sync_fifo.sv | 47 ++++
 rtl/io_port_responder.sv | 158 +++++++++++++++
 tb/tb_io_port_responder.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_port_pkg.sv
`default_nettype none
// ============================================================================
// Module      : io_port_pkg
// Description : Port map and STATUS bit positions for io_port_responder.
// Revision    : 1.0 - initial release
// ============================================================================
package io_port_pkg;

    localparam logic [7:0] GPIO_OUT0 = 8'h00;
    localparam logic [7:0] GPIO_OUT1 = 8'h01;
    localparam logic [7:0] GPIO_OUT2 = 8'h02;
    localparam logic [7:0] GPIO_OUT3 = 8'h03;
    localparam logic [7:0] GPIO_IN   = 8'h04;
    localparam logic [7:0] TX_DATA   = 8'h10;
    localparam logic [7:0] RX_DATA   = 8'h11;
    localparam logic [7:0] STATUS    = 8'h12;
    localparam logic [7:0] IRQ_MASK  = 8'h13;

    localparam int c_st_tx_full       = 7;
    localparam int c_st_tx_empty      = 6;
    localparam int c_st_rx_full       = 5;
    localparam int c_st_rx_empty      = 4;
    localparam int c_st_tx_drop       = 3;
    localparam int c_st_rx_underflow  = 2;

endpackage
`default_nettype wire

// File: rtl/io_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : io_sync_fifo
// Description : First-word-fall-through synchronous FIFO, wrap-bit pointers.
// Revision    : 1.0 - initial release
// ============================================================================
module io_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;

    // Callers only assert i_push when not full (or popping) and i_pop when not empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (i_push) r_wptr <= r_wptr + {{AW{1'b0}}, 1'b1};
            if (i_pop)  r_rptr <= r_rptr + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wptr[AW-1:0]] <= i_data;
    end

    assign o_head  = r_mem[r_rptr[AW-1:0]];
    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[AW] != r_rptr[AW]) &&
                     (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

endmodule
`default_nettype wire

// File: rtl/io_port_responder.sv
`default_nettype none
// ============================================================================
// Module      : io_port_responder
// Description : IO-bus responder: GPIO, TX/RX byte FIFOs, STATUS, optional IRQ
//               (IRQ logic built only when IO_RESPONDER_IRQ_EN is defined).
// Revision    : 1.0 - initial release
// ============================================================================
module io_port_responder
    import io_port_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int FIFO_AW    = 3
) (
    input  logic        clk100,
    input  logic        reset,
    input  logic [7:0]  IO_port_ID,
    input  logic [7:0]  IO_write_data,
    input  logic        IO_write_strobe,
    input  logic        IO_read_strobe,
    output logic [7:0]  IO_read_data,
    output logic [31:0] gpio_out,
    input  logic [7:0]  gpio_in,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        irq
);

    logic        w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
    logic [7:0]  w_tx_head, w_rx_head;
    logic        w_wr_tx, w_tx_pop, w_tx_push;
    logic        w_rd_rx, w_rx_pop, w_rx_push;
    logic        w_status_wr;
    logic [7:0]  w_status;
    logic [7:0]  w_irq_mask_rd;
    logic [31:0] r_gpio_out;
    logic [7:0]  r_gpio_meta, r_gpio_sync;
    logic        r_tx_drop, r_rx_underflow;

    assign w_tx_pop    = !w_tx_empty && tx_ready;
    assign w_wr_tx     = IO_write_strobe && (IO_port_ID == TX_DATA);
    assign w_tx_push   = w_wr_tx && (!w_tx_full || w_tx_pop);
    assign w_rd_rx     = IO_read_strobe && (IO_port_ID == RX_DATA);
    assign w_rx_pop    = w_rd_rx && !w_rx_empty;
    assign w_rx_push   = rx_valid && !w_rx_full;
    assign w_status_wr = IO_write_strobe && (IO_port_ID == STATUS);

    io_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH), .AW(FIFO_AW)) u_tx_fifo (
        .clk     (clk100),
        .rst_n   (reset),
        .i_push  (w_tx_push),
        .i_data  (IO_write_data),
        .i_pop   (w_tx_pop),
        .o_head  (w_tx_head),
        .o_full  (w_tx_full),
        .o_empty (w_tx_empty)
    );

    io_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH), .AW(FIFO_AW)) u_rx_fifo (
        .clk     (clk100),
        .rst_n   (reset),
        .i_push  (w_rx_push),
        .i_data  (rx_data),
        .i_pop   (w_rx_pop),
        .o_head  (w_rx_head),
        .o_full  (w_rx_full),
        .o_empty (w_rx_empty)
    );

    assign tx_valid = !w_tx_empty;
    assign tx_data  = w_tx_head;
    assign rx_ready = !w_rx_full;
    assign gpio_out = r_gpio_out;

    always_ff @(posedge clk100 or negedge reset) begin
        if (!reset) begin
            r_gpio_out     <= '0;
            r_gpio_meta    <= '0;
            r_gpio_sync    <= '0;
            r_tx_drop      <= 1'b0;
            r_rx_underflow <= 1'b0;
        end else begin
            r_gpio_meta <= gpio_in;
            r_gpio_sync <= r_gpio_meta;
            if (IO_write_strobe) begin
                case (IO_port_ID)
                    GPIO_OUT0: r_gpio_out[7:0]   <= IO_write_data;
                    GPIO_OUT1: r_gpio_out[15:8]  <= IO_write_data;
                    GPIO_OUT2: r_gpio_out[23:16] <= IO_write_data;
                    GPIO_OUT3: r_gpio_out[31:24] <= IO_write_data;
                    default: ;
                endcase
            end
            // Sticky set takes priority over a same-edge W1C clear.
            if (w_wr_tx && w_tx_full && !w_tx_pop)
                r_tx_drop <= 1'b1;
            else if (w_status_wr && IO_write_data[c_st_tx_drop])
                r_tx_drop <= 1'b0;
            if (w_rd_rx && w_rx_empty)
                r_rx_underflow <= 1'b1;
            else if (w_status_wr && IO_write_data[c_st_rx_underflow])
                r_rx_underflow <= 1'b0;
        end
    end

`ifdef IO_RESPONDER_IRQ_EN
    logic [1:0] r_irq_mask;
    logic       r_irq;

    always_ff @(posedge clk100 or negedge reset) begin
        if (!reset) begin
            r_irq_mask <= 2'b00;
            r_irq      <= 1'b0;
        end else begin
            if (IO_write_strobe && (IO_port_ID == IRQ_MASK))
                r_irq_mask <= IO_write_data[1:0];
            r_irq <= (r_irq_mask[0] && !w_rx_empty) || (r_irq_mask[1] && r_tx_drop);
        end
    end

    assign irq           = r_irq;
    assign w_irq_mask_rd = {6'b000000, r_irq_mask};
`else
    assign irq           = 1'b0;
    assign w_irq_mask_rd = 8'h00;
`endif

    always_comb begin
        w_status                    = 8'h00;
        w_status[c_st_tx_full]      = w_tx_full;
        w_status[c_st_tx_empty]     = w_tx_empty;
        w_status[c_st_rx_full]      = w_rx_full;
        w_status[c_st_rx_empty]     = w_rx_empty;
        w_status[c_st_tx_drop]      = r_tx_drop;
        w_status[c_st_rx_underflow] = r_rx_underflow;
    end

    // Zero-latency read mux; an empty RX FIFO reads as 0x00 rather than stale storage.
    always_comb begin
        IO_read_data = 8'h00;
        case (IO_port_ID)
            GPIO_OUT0: IO_read_data = r_gpio_out[7:0];
            GPIO_OUT1: IO_read_data = r_gpio_out[15:8];
            GPIO_OUT2: IO_read_data = r_gpio_out[23:16];
            GPIO_OUT3: IO_read_data = r_gpio_out[31:24];
            GPIO_IN:   IO_read_data = r_gpio_sync;
            RX_DATA:   IO_read_data = w_rx_empty ? 8'h00 : w_rx_head;
            STATUS:    IO_read_data = w_status;
            IRQ_MASK:  IO_read_data = w_irq_mask_rd;
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_io_port_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_io_port_responder
// Description : Self-checking bench for io_port_responder with queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_io_port_responder;

    localparam int DEPTH = 8;

    logic        clk100;
    logic        reset;
    logic [7:0]  IO_port_ID;
    logic [7:0]  IO_write_data;
    logic        IO_write_strobe;
    logic        IO_read_strobe;
    logic [7:0]  IO_read_data;
    logic [31:0] gpio_out;
    logic [7:0]  gpio_in;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        irq;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    logic [7:0] m_gpio [4];
    logic [7:0] m_s1, m_s2;
    logic       m_tx_drop, m_rx_uf, m_irq;
    logic [1:0] m_mask;

    logic [7:0] ids [12] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h10,
                             8'h11, 8'h12, 8'h13, 8'h20, 8'h7F, 8'h05};

    io_port_responder #(.FIFO_DEPTH(DEPTH), .FIFO_AW(3)) dut (
        .clk100          (clk100),
        .reset           (reset),
        .IO_port_ID      (IO_port_ID),
        .IO_write_data   (IO_write_data),
        .IO_write_strobe (IO_write_strobe),
        .IO_read_strobe  (IO_read_strobe),
        .IO_read_data    (IO_read_data),
        .gpio_out        (gpio_out),
        .gpio_in         (gpio_in),
        .tx_data         (tx_data),
        .tx_valid        (tx_valid),
        .tx_ready        (tx_ready),
        .rx_data         (rx_data),
        .rx_valid        (rx_valid),
        .rx_ready        (rx_ready),
        .irq             (irq)
    );

    initial clk100 = 1'b0;
    always #5 clk100 = ~clk100;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        tx_q.delete();
        rx_q.delete();
        for (int i = 0; i < 4; i++) m_gpio[i] = 8'h00;
        m_s1 = 8'h00; m_s2 = 8'h00;
        m_tx_drop = 1'b0; m_rx_uf = 1'b0; m_irq = 1'b0; m_mask = 2'b00;
    endtask

    function automatic logic [7:0] m_read(input logic [7:0] id);
        logic [7:0] v;
        v = 8'h00;
        if (id <= 8'h03) v = m_gpio[id[1:0]];
        else if (id == 8'h04) v = m_s2;
        else if (id == 8'h11) v = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
        else if (id == 8'h12)
            v = {tx_q.size() == DEPTH, tx_q.size() == 0, rx_q.size() == DEPTH,
                 rx_q.size() == 0, m_tx_drop, m_rx_uf, 2'b00};
`ifdef IO_RESPONDER_IRQ_EN
        else if (id == 8'h13) v = {6'b000000, m_mask};
`endif
        return v;
    endfunction

    // One clock edge of spec behaviour, evaluated from the inputs present at the edge.
    task automatic model_edge();
        int  tx_n, rx_n;
        bit  tx_pop, drop_set, uf_set, irq_next;
        tx_n     = tx_q.size();
        rx_n     = rx_q.size();
        irq_next = (m_mask[0] && rx_n != 0) || (m_mask[1] && m_tx_drop);
        tx_pop   = tx_ready && tx_n != 0;
        drop_set = 1'b0;
        uf_set   = 1'b0;
        if (tx_pop) void'(tx_q.pop_front());
        if (IO_write_strobe && IO_port_ID == 8'h10) begin
            if (tx_n < DEPTH || tx_pop) tx_q.push_back(IO_write_data);
            else drop_set = 1'b1;
        end
        if (IO_read_strobe && IO_port_ID == 8'h11) begin
            if (rx_n == 0) uf_set = 1'b1;
            else void'(rx_q.pop_front());
        end
        if (rx_valid && rx_n < DEPTH) rx_q.push_back(rx_data);
        if (IO_write_strobe && IO_port_ID == 8'h12) begin
            if (IO_write_data[3]) m_tx_drop = 1'b0;
            if (IO_write_data[2]) m_rx_uf = 1'b0;
        end
        if (drop_set) m_tx_drop = 1'b1;
        if (uf_set) m_rx_uf = 1'b1;
        if (IO_write_strobe && IO_port_ID <= 8'h03) m_gpio[IO_port_ID[1:0]] = IO_write_data;
`ifdef IO_RESPONDER_IRQ_EN
        if (IO_write_strobe && IO_port_ID == 8'h13) m_mask = IO_write_data[1:0];
        m_irq = irq_next;
`endif
        m_s2 = m_s1;
        m_s1 = gpio_in;
    endtask

    task automatic tick();
        @(posedge clk100);
        if (reset) model_edge();
        #1;
    endtask

    task automatic check_all();
        #1;
        check("rdata", IO_read_data, m_read(IO_port_ID));
        check("tx_valid", tx_valid, tx_q.size() != 0);
        if (tx_q.size() != 0) check("tx_data", tx_data, tx_q[0]);
        check("rx_ready", rx_ready, rx_q.size() < DEPTH);
        check("gpio_out", gpio_out, {m_gpio[3], m_gpio[2], m_gpio[1], m_gpio[0]});
        check("irq", irq, m_irq);
    endtask

    task automatic io_write(input logic [7:0] id, input logic [7:0] d);
        IO_port_ID = id; IO_write_data = d; IO_write_strobe = 1'b1;
        tick();
        IO_write_strobe = 1'b0;
    endtask

    task automatic io_read(input logic [7:0] id, output logic [7:0] v);
        IO_port_ID = id; IO_read_strobe = 1'b1;
        #1;
        v = IO_read_data;
        check("io_read", v, m_read(id));
        tick();
        IO_read_strobe = 1'b0;
    endtask

    task automatic peek(input logic [7:0] id, output logic [7:0] v);
        IO_port_ID = id;
        #1;
        v = IO_read_data;
    endtask

    initial begin
        logic [7:0] v;
        reset = 1'b0; IO_port_ID = 8'h00; IO_write_data = 8'h00;
        IO_write_strobe = 1'b0; IO_read_strobe = 1'b0; gpio_in = 8'h00;
        tx_ready = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;
        model_reset();
        tick(); tick();
        reset = 1'b1;

        // Reset state
        peek(8'h12, v);
        check("status_reset", v, 8'h50);
        check("tx_valid_reset", tx_valid, 1'b0);
        check("rx_ready_reset", rx_ready, 1'b1);
        check("gpio_reset", gpio_out, 32'h0);
        check("irq_reset", irq, 1'b0);

        // GPIO out and synchronized input
        io_write(8'h02, 8'hA5);
        check("gpio2_out", gpio_out[23:16], 8'hA5);
        io_read(8'h02, v);
        check("gpio2_read", v, 8'hA5);
        gpio_in = 8'h3C;
        tick();
        peek(8'h04, v);
        check("gpio_in_1edge", v, 8'h00);
        tick();
        peek(8'h04, v);
        check("gpio_in_2edge", v, 8'h3C);

        // TX fill with overflow, drain, W1C
        for (int i = 1; i <= 9; i++) io_write(8'h10, 8'(i));
        peek(8'h12, v);
        check("status_tx_full_drop", v & 8'hE8, 8'h88);
        check_all();
        tx_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            #1;
            check("drain_valid", tx_valid, 1'b1);
            check("drain_data", tx_data, 8'(i));
            tick();
        end
        check("drain_done", tx_valid, 1'b0);
        tx_ready = 1'b0;
        io_write(8'h12, 8'h08);
        peek(8'h12, v);
        check("status_w1c", v & 8'hE8, 8'h40);
        check_all();

        // RX push then pops, then underflow
        rx_valid = 1'b1;
        rx_data = 8'h11; tick();
        rx_data = 8'h22; tick();
        rx_data = 8'h33; tick();
        rx_valid = 1'b0;
        io_read(8'h11, v); check("rx_pop1", v, 8'h11);
        io_read(8'h11, v); check("rx_pop2", v, 8'h22);
        io_read(8'h11, v); check("rx_pop3", v, 8'h33);
        io_read(8'h11, v); check("rx_underflow_data", v, 8'h00);
        peek(8'h12, v);
        check("rx_underflow_bit", v[2], 1'b1);

        // RX full boundary with rx_valid held
        rx_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rx_data = 8'h40 + 8'(i);
            tick();
        end
        check("rx_full_ready", rx_ready, 1'b0);
        rx_data = 8'h48;
        io_read(8'h11, v);
        check("rx_full_pop", v, 8'h40);
        check("rx_ready_after_pop", rx_ready, 1'b1);
        tick();
        check("rx_refull", rx_ready, 1'b0);
        rx_valid = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            io_read(8'h11, v);
            check("rx_order", v, 8'h40 + 8'(i));
        end
        peek(8'h12, v);
        check("rx_empty_after", v[4], 1'b1);

        // Asynchronous reset during TX drain
        io_write(8'h12, 8'h0C);
        io_write(8'h10, 8'hAA);
        io_write(8'h10, 8'hBB);
        io_write(8'h10, 8'hCC);
        tx_ready = 1'b1;
        IO_port_ID = 8'h12;
        check_all();
        tick();
        check("pre_reset_valid", tx_valid, 1'b1);
        reset = 1'b0;
        #1;
        check("reset_tx_valid", tx_valid, 1'b0);
        check("reset_rx_ready", rx_ready, 1'b1);
        check("reset_status", IO_read_data, 8'h50);
        check("reset_gpio", gpio_out, 32'h0);
        model_reset();
        tick(); tick();
        reset = 1'b1;
        tx_ready = 1'b0;
        check_all();

`ifdef IO_RESPONDER_IRQ_EN
        io_write(8'h13, 8'h01);
        rx_valid = 1'b1; rx_data = 8'h5A;
        tick();
        rx_valid = 1'b0;
        check("irq_lag", irq, 1'b0);
        tick();
        check("irq_set", irq, 1'b1);
        io_read(8'h11, v);
        check("irq_hold", irq, 1'b1);
        tick();
        check("irq_clear", irq, 1'b0);
        check_all();
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 1) == 0)
                IO_port_ID = ($urandom_range(0, 1) == 0) ? 8'h10 : 8'h11;
            else
                IO_port_ID = ids[$urandom_range(0, 11)];
            IO_write_data   = 8'($urandom);
            IO_write_strobe = ($urandom_range(0, 1) == 0);
            IO_read_strobe  = !IO_write_strobe && ($urandom_range(0, 2) == 0);
            if (i < 300) begin
                tx_ready = ($urandom_range(0, 7) == 0);
                rx_valid = ($urandom_range(0, 3) != 0);
            end else begin
                tx_ready = ($urandom_range(0, 3) != 0);
                rx_valid = ($urandom_range(0, 7) == 0);
            end
            rx_data = 8'($urandom);
            if ($urandom_range(0, 7) == 0) gpio_in = 8'($urandom);
            check_all();
            tick();
        end
        IO_write_strobe = 1'b0;
        IO_read_strobe  = 1'b0;
        check_all();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
